// File: rtl/dircc_timer_pkg.sv
// Shared register map and bit positions for the DiRCC multi-channel timer.
// Imported by the channel and the bus-facing top level.
package dircc_timer_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_off_e;

  localparam int CTL_ITO       = 0;
  localparam int CTL_CONT      = 1;
  localparam int CTL_START     = 2;
  localparam int CTL_STOP      = 3;
  localparam int CTL_PRESC_LSB = 8;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

endpackage

// File: rtl/dircc_timer_channel.sv
// One down-counting interval timer with prescaler, snapshot and interrupt.
// Driven by decoded per-register write strobes from the bus top level.
module dircc_timer_channel
  import dircc_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRESCALE_W   = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wrStatus,
  input  logic        i_wrControl,
  input  logic        i_wrPeriod,
  input  logic        i_wrSnap,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_status,
  output logic [31:0] o_control,
  output logic [31:0] o_period,
  output logic [31:0] o_snap,
  output logic        o_irq
);

  localparam int PW = (PRESCALE_W > 0) ? PRESCALE_W : 1;
  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_snap;
  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    r_pcnt;
  logic             r_to;
  logic             r_run;
  logic             r_ito;
  logic             r_cont;
  logic             r_periodPend;

  logic             w_start;
  logic             w_stop;
  logic             w_tick;
  logic             w_zero;
  logic [PW-1:0]    w_prescIn;
  logic             w_unused;

  assign w_start  = i_wrControl && i_wdata[CTL_START];
  assign w_stop   = i_wrControl && i_wdata[CTL_STOP];
  assign w_unused = ^i_wdata;

  generate
    if (PRESCALE_W > 0) begin : g_presc
      assign w_prescIn = i_wdata[CTL_PRESC_LSB +: PW];
    end else begin : g_noPresc
      assign w_prescIn = '0;
    end
  endgenerate

  // The >= guards against PRESC being lowered below an in-flight prescale count.
  assign w_tick = r_run && !r_periodPend && (r_pcnt >= r_presc);
  assign w_zero = (r_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= RST_VAL;
      r_period     <= RST_VAL;
      r_snap       <= '0;
      r_presc      <= '0;
      r_pcnt       <= '0;
      r_to         <= 1'b0;
      r_run        <= 1'b0;
      r_ito        <= 1'b0;
      r_cont       <= 1'b0;
      r_periodPend <= 1'b0;
    end else begin
      if (i_wrControl) begin
        r_ito   <= i_wdata[CTL_ITO];
        r_cont  <= i_wdata[CTL_CONT];
        r_presc <= w_prescIn;
      end

      if (i_wrPeriod) begin
        r_period     <= i_wdata[CNT_W-1:0];
        r_periodPend <= 1'b1;
      end else begin
        r_periodPend <= 1'b0;
      end

      if (i_wrSnap) begin
        r_snap <= r_count;
      end

      if (w_tick && w_zero) begin
        r_to <= 1'b1;
      end else if (i_wrStatus) begin
        r_to <= 1'b0;
      end

      // A pending period load owns the cycle: it reloads, stops and swallows START.
      if (r_periodPend) begin
        r_count <= r_period;
        r_run   <= 1'b0;
        r_pcnt  <= '0;
      end else begin
        if (w_tick) begin
          r_pcnt <= '0;
          if (w_zero) begin
            r_count <= r_period;
            r_run   <= r_cont;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end else if (r_run) begin
          r_pcnt <= r_pcnt + 1'b1;
        end

        if (w_start) begin
          r_run <= 1'b1;
          if (!r_run) begin
            r_pcnt <= '0;
          end
        end else if (w_stop) begin
          r_run <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_status         = '0;
    o_status[ST_TO]  = r_to;
    o_status[ST_RUN] = r_run;

    o_control                          = '0;
    o_control[CTL_ITO]                 = r_ito;
    o_control[CTL_CONT]                = r_cont;
    o_control[CTL_PRESC_LSB +: PW]     = r_presc;
  end

  assign o_period = 32'(r_period);
  assign o_snap   = 32'(r_snap);
  assign o_irq    = r_to && r_ito;

endmodule

// File: rtl/dircc_multi_channel_timer.sv
// Avalon-MM slave wrapping NUM_CH independent interval timers.
// Decodes channel/register from the word address and registers the read mux.
module dircc_multi_channel_timer
  import dircc_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRESCALE_W   = 8,
  parameter int RESET_PERIOD = 49999,
  localparam int AW          = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [31:0]       w_chIdx;
  reg_off_e          w_reg;
  logic              w_wr;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_irq;
  logic [31:0]       w_status  [NUM_CH];
  logic [31:0]       w_control [NUM_CH];
  logic [31:0]       w_period  [NUM_CH];
  logic [31:0]       w_snap    [NUM_CH];
  logic [31:0]       w_rdata;
  logic [31:0]       r_readdata;

  // Channel indices at or above NUM_CH match no channel, so they read 0 and drop writes.
  assign w_chIdx = 32'(address) >> 2;
  assign w_reg   = reg_off_e'(address[1:0]);
  assign w_wr    = chipselect && !write_n;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_sel[g] = w_wr && (w_chIdx == 32'(g));

      dircc_timer_channel #(
        .CNT_W       (CNT_W),
        .PRESCALE_W  (PRESCALE_W),
        .RESET_PERIOD(RESET_PERIOD)
      ) u_channel (
        .clk        (clk),
        .reset      (reset),
        .i_wrStatus (w_sel[g] && (w_reg == REG_STATUS)),
        .i_wrControl(w_sel[g] && (w_reg == REG_CONTROL)),
        .i_wrPeriod (w_sel[g] && (w_reg == REG_PERIOD)),
        .i_wrSnap   (w_sel[g] && (w_reg == REG_SNAP)),
        .i_wdata    (writedata),
        .o_status   (w_status[g]),
        .o_control  (w_control[g]),
        .o_period   (w_period[g]),
        .o_snap     (w_snap[g]),
        .o_irq      (w_irq[g])
      );
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_chIdx == 32'(c)) begin
        case (w_reg)
          REG_STATUS:  w_rdata = w_status[c];
          REG_CONTROL: w_rdata = w_control[c];
          REG_PERIOD:  w_rdata = w_period[c];
          REG_SNAP:    w_rdata = w_snap[c];
          default:     w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = w_irq;
  assign irq_any  = |w_irq;

endmodule

// File: tb/tb_dircc_multi_channel_timer.sv
// Self-checking bench for dircc_multi_channel_timer: register vectors,
// randomized timeout-interval trials and hand-written corner sequences.
module tb_dircc_multi_channel_timer;

  localparam int NUM_CH = 4;
  localparam int AW     = $clog2(NUM_CH) + 2;
  localparam int AW3    = $clog2(3) + 2;
  localparam logic [31:0] RST_P = 32'd49999;

  logic              clk;
  logic              reset;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;

  logic [AW3-1:0]    address3;
  logic              chipselect3;
  logic              write_n3;
  logic [31:0]       writedata3;
  logic [31:0]       readdata3;
  logic [2:0]        irq3;
  logic              irqAny3;

  int compareCount  = 0;
  int mismatchCount = 0;

  typedef struct {
    int          ch;
    int          regOff;
    bit          doWrite;
    logic [31:0] wdata;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[11];

  dircc_multi_channel_timer #(.NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .irq_any   (irq_any)
  );

  dircc_multi_channel_timer #(.NUM_CH(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .address   (address3),
    .chipselect(chipselect3),
    .write_n   (write_n3),
    .writedata (writedata3),
    .readdata  (readdata3),
    .irq       (irq3),
    .irq_any   (irqAny3)
  );

  // Free-running clock; the bench drives and samples on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic busWrite(input int ch, input int regOff, input logic [31:0] data);
    address    = AW'(ch * 4 + regOff);
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = data;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic busRead(input int ch, input int regOff, output logic [31:0] data);
    address    = AW'(ch * 4 + regOff);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    data       = readdata;
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] rd;
    if (v.doWrite) busWrite(v.ch, v.regOff, v.wdata);
    busRead(v.ch, v.regOff, rd);
    checkOutput($sformatf("vec%0d", idx), rd, v.expected);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        early;
    int          ch;
    int          p;
    int          q;
    int          t;
    bit          cont;
    bit          ito;

    reset       = 1'b1;
    address     = '0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    address3    = '0;
    chipselect3 = 1'b0;
    write_n3    = 1'b1;
    writedata3  = '0;

    idle(2);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;

    vecs[0]  = '{0, 0, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{0, 2, 1'b0, 32'h0,         RST_P};
    vecs[2]  = '{0, 3, 1'b0, 32'h0,         32'h0};
    vecs[3]  = '{0, 1, 1'b0, 32'h0,         32'h0};
    vecs[4]  = '{3, 2, 1'b0, 32'h0,         RST_P};
    vecs[5]  = '{1, 1, 1'b1, 32'hFFFF_FFF3, 32'h0000_FF03};
    vecs[6]  = '{1, 2, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[7]  = '{2, 0, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{2, 3, 1'b1, 32'h1234_5678, RST_P};
    vecs[9]  = '{3, 1, 1'b1, 32'h0000_0C08, 32'h0000_0C00};
    vecs[10] = '{0, 2, 1'b0, 32'h0,         RST_P};

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);
    checkOutput("vec_irq_quiet", 32'(irq_any), 32'h0);

    doReset();

    // Randomized trials: a timeout lands exactly (P+1)*(PRESC+1) clocks after START.
    for (int trial = 0; trial < 10; trial++) begin
      ch   = int'($urandom_range(NUM_CH - 1, 0));
      p    = int'($urandom_range(12, 0));
      q    = int'($urandom_range(3, 0));
      cont = 1'($urandom_range(1, 0));
      ito  = 1'($urandom_range(1, 0));
      t    = (p + 1) * (q + 1);
      busWrite(ch, 2, 32'(p));
      idle(1);
      busWrite(ch, 1, 32'(ito) | (32'(cont) << 1) | 32'h4 | (32'(q) << 8));
      early = 1'b0;
      for (int k = 1; k < t; k++) begin
        @(negedge clk);
        if (irq !== '0) early = 1'b1;
      end
      @(negedge clk);
      checkOutput($sformatf("rand%0d_early", trial), 32'(early), 32'h0);
      checkOutput($sformatf("rand%0d_irq", trial), 32'(irq[ch]), 32'(ito));
      checkOutput($sformatf("rand%0d_irqany", trial), 32'(irq_any), 32'(ito));
      busRead(ch, 0, rd);
      checkOutput($sformatf("rand%0d_status", trial), rd, 32'h1 | (32'(cont) << 1));
      busWrite(ch, 1, 32'h8);
      busWrite(ch, 0, 32'h0);
    end

    // ch1 continuous, period 9, no prescale.
    busWrite(1, 2, 32'd9);
    idle(1);
    busWrite(1, 1, 32'h07);
    early = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (irq[1] !== 1'b0) early = 1'b1;
    end
    @(negedge clk);
    checkOutput("t2_early", 32'(early), 32'h0);
    checkOutput("t2_irq_first", 32'(irq[1]), 32'h1);
    busWrite(1, 0, 32'h0);
    checkOutput("t2_irq_cleared", 32'(irq[1]), 32'h0);
    idle(8);
    checkOutput("t2_irq_before_second", 32'(irq[1]), 32'h0);
    idle(1);
    checkOutput("t2_irq_second", 32'(irq[1]), 32'h1);
    checkOutput("t2_irqany", 32'(irq_any), 32'h1);
    busWrite(1, 1, 32'h8);
    busWrite(1, 0, 32'h0);

    // ch2 one-shot, period 4, prescale 3, interrupt masked.
    busWrite(2, 2, 32'd4);
    idle(1);
    busWrite(2, 1, 32'h304);
    idle(19);
    busRead(2, 0, rd);
    checkOutput("t3_status_pre", rd, 32'h2);
    busRead(2, 0, rd);
    checkOutput("t3_status_post", rd, 32'h1);
    checkOutput("t3_irqany", 32'(irq_any), 32'h0);
    idle(5);
    busWrite(2, 3, 32'h0);
    busRead(2, 3, rd);
    checkOutput("t3_count_hold", rd, 32'd4);

    // ch0 period rewrite while running; START in the load cycle is dropped.
    busWrite(0, 2, 32'd100);
    idle(1);
    busWrite(0, 1, 32'h06);
    idle(30);
    busWrite(0, 2, 32'd50);
    busWrite(0, 1, 32'h06);
    idle(1);
    busRead(0, 0, rd);
    checkOutput("t4_status", rd, 32'h0);
    busWrite(0, 3, 32'h0);
    busRead(0, 3, rd);
    checkOutput("t4_snap", rd, 32'd50);

    // ch3 STATUS write colliding with a timeout, then STOP / START|STOP.
    busWrite(3, 2, 32'd4);
    idle(1);
    busWrite(3, 1, 32'h07);
    idle(4);
    busWrite(3, 0, 32'h0);
    checkOutput("t5_set_wins", 32'(irq[3]), 32'h1);
    busWrite(3, 0, 32'h0);
    checkOutput("t5_clear", 32'(irq[3]), 32'h0);
    busWrite(3, 1, 32'h0B);
    busRead(3, 0, rd);
    checkOutput("t5_stop", rd, 32'h0);
    busWrite(3, 1, 32'h0F);
    busRead(3, 0, rd);
    checkOutput("t5_start_wins", rd, 32'h2);
    busWrite(3, 1, 32'h8);
    busWrite(3, 0, 32'h0);

    // ch1 traffic must leave ch0 and ch2 untouched.
    busWrite(1, 2, 32'd7);
    idle(1);
    busWrite(1, 1, 32'h07);
    idle(10);
    busWrite(1, 3, 32'h0);
    busWrite(1, 0, 32'h0);
    busWrite(1, 1, 32'h8);
    busRead(2, 0, rd);
    checkOutput("iso_ch2_status", rd, 32'h1);
    busWrite(2, 3, 32'h0);
    busRead(2, 3, rd);
    checkOutput("iso_ch2_count", rd, 32'd4);
    busRead(0, 0, rd);
    checkOutput("iso_ch0_status", rd, 32'h0);
    busWrite(0, 3, 32'h0);
    busRead(0, 3, rd);
    checkOutput("iso_ch0_count", rd, 32'd50);

    // Asynchronous reset with every channel running and interrupting.
    for (int c = 0; c < NUM_CH; c++) busWrite(c, 2, 32'd2);
    idle(1);
    for (int c = 0; c < NUM_CH; c++) busWrite(c, 1, 32'h07);
    idle(5);
    checkOutput("rst_pre_irq", 32'(irq), 32'hF);
    busRead(0, 2, rd);
    checkOutput("rst_pre_readdata", rd, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_irq", 32'(irq), 32'h0);
    checkOutput("rst_async_irqany", 32'(irq_any), 32'h0);
    checkOutput("rst_async_readdata", readdata, 32'h0);
    idle(2);
    reset = 1'b0;
    busRead(0, 0, rd);
    checkOutput("rst_status", rd, 32'h0);
    busRead(0, 2, rd);
    checkOutput("rst_period", rd, RST_P);
    busRead(0, 1, rd);
    checkOutput("rst_control", rd, 32'h0);
    busWrite(0, 1, 32'h04);
    idle(3);
    busWrite(0, 3, 32'h0);
    busRead(0, 3, rd);
    checkOutput("rst_first_ticks", rd, RST_P - 32'd3);

    // NUM_CH=3 build: channel index 3 is unmapped.
    @(negedge clk);
    address3    = AW3'(4'hE);
    chipselect3 = 1'b1;
    write_n3    = 1'b0;
    writedata3  = 32'd77;
    @(negedge clk);
    write_n3    = 1'b1;
    @(negedge clk);
    checkOutput("nc3_unmapped_period", readdata3, 32'h0);
    address3    = AW3'(4'hC);
    @(negedge clk);
    checkOutput("nc3_unmapped_status", readdata3, 32'h0);
    address3    = AW3'(4'h2);
    @(negedge clk);
    checkOutput("nc3_mapped_period", readdata3, RST_P);
    chipselect3 = 1'b0;
    checkOutput("nc3_irqany", 32'(irqAny3), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
